// File: rtl/h264_tq_pkg.sv
// Definitions shared by the intra 4x4 transform/quant, coefficient scan and CAVLC stages.
package h264_tq_pkg;

    localparam int TQ_COEF_W = 15;

    typedef logic signed [TQ_COEF_W-1:0] coef_t;

    // Raster index (row*4+col) visited at each zig-zag scan position
    localparam logic [3:0] ZIGZAG_4x4 [16] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_STATS = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

endpackage

// File: rtl/coef_level_fifo.sv
// 16-entry level/run store: written by scan position, read back newest-first.
module coef_level_fifo #(
    parameter int COEF_W = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [3:0]               wr_idx,
    input  logic signed [COEF_W-1:0] wr_level,
    input  logic [3:0]               wr_run,
    input  logic                     rd_load,
    input  logic [3:0]               rd_start,
    input  logic                     rd_pop,
    output logic signed [COEF_W-1:0] rd_level,
    output logic [3:0]               rd_run,
    output logic [3:0]               rd_idx,
    output logic [15:0]              ones_mask
);

    logic signed [COEF_W-1:0] level_mem [16];
    logic [3:0]               run_mem   [16];
    logic [3:0]               rd_ptr;
    logic                     wr_unit;

    // Flag +/-1 at write time so trailing-ones needs no magnitude logic later
    assign wr_unit = (wr_level == {{(COEF_W-1){1'b0}}, 1'b1}) ||
                     (wr_level == {COEF_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                level_mem[i] <= '0;
                run_mem[i]   <= '0;
            end
            ones_mask <= '0;
            rd_ptr    <= '0;
        end else if (clear) begin
            for (int i = 0; i < 16; i++) begin
                level_mem[i] <= '0;
                run_mem[i]   <= '0;
            end
            ones_mask <= '0;
            rd_ptr    <= '0;
        end else begin
            if (wr_en) begin
                level_mem[wr_idx] <= wr_level;
                run_mem[wr_idx]   <= wr_run;
                ones_mask[wr_idx] <= wr_unit;
            end
            if (rd_load)
                rd_ptr <= rd_start;
            else if (rd_pop)
                rd_ptr <= rd_ptr - 4'd1;
        end
    end

    assign rd_level = level_mem[rd_ptr];
    assign rd_run   = run_mem[rd_ptr];
    assign rd_idx   = rd_ptr;

endmodule

// File: rtl/intra_4x4_coef_scan.sv
// Zig-zag scans a quantised 4x4 block, derives CAVLC statistics and streams levels in reverse scan order.
module intra_4x4_coef_scan
    import h264_tq_pkg::*;
#(
    parameter int COEF_W    = 15,
    parameter int START_IDX = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     h264_reset,
    input  logic                     coef_valid,
    output logic                     coef_ready,
    input  logic signed [COEF_W-1:0] coef_i [0:3][0:3],
    output logic                     blk_info_valid,
    output logic [4:0]               blk_total_coeff,
    output logic [1:0]               blk_trailing_ones,
    output logic [3:0]               blk_total_zeros,
    output logic                     lvl_valid,
    input  logic                     lvl_ready,
    output logic signed [COEF_W-1:0] lvl_level,
    output logic [3:0]               lvl_run,
    output logic                     lvl_last,
    output logic                     blk_done
);

    scan_state_e              state;
    logic signed [COEF_W-1:0] coef_q [16];
    logic [3:0]               k;
    logic [4:0]               n, zrun, zeros_seen;
    logic [3:0]               tz;
    logic [4:0]               total_coeff_q;
    logic [1:0]               trailing_ones_q;
    logic [3:0]               total_zeros_q;
    logic signed [COEF_W-1:0] cur, rd_level;
    logic [3:0]               rd_run, rd_idx;
    logic [15:0]              ones_mask;
    logic                     wr_en;

    // Consecutive +/-1 levels counted from the highest-frequency non-zero downward
    function automatic logic [1:0] calc_trailing_ones(input logic [15:0] ones, input logic [4:0] cnt);
        logic [1:0] t;
        logic       run_on;
        t      = 2'd0;
        run_on = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (5'(i) < cnt && run_on) begin
                if (ones[i]) begin
                    if (t != 2'd3) t = t + 2'd1;
                end else begin
                    run_on = 1'b0;
                end
            end
        end
        return t;
    endfunction

    assign cur   = coef_q[ZIGZAG_4x4[k]];
    assign wr_en = (state == ST_SCAN) && (cur != '0);

    coef_level_fifo #(.COEF_W(COEF_W)) u_level_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (h264_reset),
        .wr_en     (wr_en),
        .wr_idx    (n[3:0]),
        .wr_level  (cur),
        .wr_run    (zrun[3:0]),
        .rd_load   (state == ST_STATS),
        .rd_start  (n[3:0] - 4'd1),
        .rd_pop    ((state == ST_EMIT) && lvl_ready),
        .rd_level  (rd_level),
        .rd_run    (rd_run),
        .rd_idx    (rd_idx),
        .ones_mask (ones_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            k               <= '0;
            n               <= '0;
            zrun            <= '0;
            zeros_seen      <= '0;
            tz              <= '0;
            total_coeff_q   <= '0;
            trailing_ones_q <= '0;
            total_zeros_q   <= '0;
            for (int i = 0; i < 16; i++) coef_q[i] <= '0;
        end else if (h264_reset) begin
            state           <= ST_IDLE;
            k               <= '0;
            n               <= '0;
            zrun            <= '0;
            zeros_seen      <= '0;
            tz              <= '0;
            total_coeff_q   <= '0;
            trailing_ones_q <= '0;
            total_zeros_q   <= '0;
            for (int i = 0; i < 16; i++) coef_q[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (coef_valid) begin
                        for (int r = 0; r < 4; r++)
                            for (int c = 0; c < 4; c++)
                                coef_q[4*r+c] <= coef_i[r][c];
                        k          <= 4'(START_IDX);
                        n          <= '0;
                        zrun       <= '0;
                        zeros_seen <= '0;
                        tz         <= '0;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cur != '0) begin
                        n    <= n + 5'd1;
                        zrun <= '0;
                        tz   <= zeros_seen[3:0];
                    end else begin
                        zrun       <= zrun + 5'd1;
                        zeros_seen <= zeros_seen + 5'd1;
                    end
                    k <= k + 4'd1;
                    if (k == 4'd15) state <= ST_STATS;
                end
                ST_STATS: begin
                    total_coeff_q   <= n;
                    total_zeros_q   <= tz;
                    trailing_ones_q <= calc_trailing_ones(ones_mask, n);
                    state           <= (n != 5'd0) ? ST_EMIT : ST_DONE;
                end
                ST_EMIT: begin
                    if (lvl_ready && rd_idx == 4'd0) state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign coef_ready        = (state == ST_IDLE);
    assign blk_info_valid    = (state == ST_EMIT) || (state == ST_DONE);
    assign blk_total_coeff   = blk_info_valid ? total_coeff_q   : '0;
    assign blk_trailing_ones = blk_info_valid ? trailing_ones_q : '0;
    assign blk_total_zeros   = blk_info_valid ? total_zeros_q   : '0;
    assign lvl_valid         = (state == ST_EMIT);
    assign lvl_level         = lvl_valid ? rd_level : '0;
    assign lvl_run           = lvl_valid ? rd_run   : '0;
    assign lvl_last          = lvl_valid && (rd_idx == 4'd0);
    assign blk_done          = (state == ST_DONE);

endmodule

// File: tb/tb_intra_4x4_coef_scan.sv
// Directed checks of intra_4x4_coef_scan: full-block and AC-only instances.
module tb_intra_4x4_coef_scan;

    logic clk = 1'b0;
    logic rst, h264_reset, cv0, cv1, lvl_ready;
    logic signed [14:0] coef_i [0:3][0:3];

    logic              cr0, iv0, lv0, last0, done0;
    logic [4:0]        tc0;
    logic [1:0]        t10;
    logic [3:0]        tz0, lr0;
    logic signed [14:0] ll0;

    logic              cr1, iv1, lv1, last1, done1;
    logic [4:0]        tc1;
    logic [1:0]        t11;
    logic [3:0]        tz1, lr1;
    logic signed [14:0] ll1;

    int n_cmp = 0;
    int n_err = 0;
    int exp_lvl [16];
    int exp_run [16];

    always #5 clk = ~clk;

    intra_4x4_coef_scan #(.COEF_W(15), .START_IDX(0)) dut (
        .clk(clk), .rst(rst), .h264_reset(h264_reset),
        .coef_valid(cv0), .coef_ready(cr0), .coef_i(coef_i),
        .blk_info_valid(iv0), .blk_total_coeff(tc0), .blk_trailing_ones(t10),
        .blk_total_zeros(tz0), .lvl_valid(lv0), .lvl_ready(lvl_ready),
        .lvl_level(ll0), .lvl_run(lr0), .lvl_last(last0), .blk_done(done0)
    );

    intra_4x4_coef_scan #(.COEF_W(15), .START_IDX(1)) dut_ac (
        .clk(clk), .rst(rst), .h264_reset(h264_reset),
        .coef_valid(cv1), .coef_ready(cr1), .coef_i(coef_i),
        .blk_info_valid(iv1), .blk_total_coeff(tc1), .blk_trailing_ones(t11),
        .blk_total_zeros(tz1), .lvl_valid(lv1), .lvl_ready(lvl_ready),
        .lvl_level(ll1), .lvl_run(lr1), .lvl_last(last1), .blk_done(done1)
    );

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_coef;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                coef_i[r][c] = '0;
    endtask

    // Expected beats are listed in emission order (highest scan index first)
    task automatic set_mixed;
        clear_coef();
        coef_i[0][1] = 15'sd3;
        coef_i[1][0] = -15'sd1;
        coef_i[0][2] = -15'sd1;
        coef_i[0][3] = 15'sd1;
        coef_i[2][1] = 15'sd1;
        exp_lvl[0] = 1;  exp_run[0] = 1;
        exp_lvl[1] = 1;  exp_run[1] = 0;
        exp_lvl[2] = -1; exp_run[2] = 2;
        exp_lvl[3] = -1; exp_run[3] = 0;
        exp_lvl[4] = 3;  exp_run[4] = 1;
    endtask

    // Accept a block on dut and advance to cycle 18 (first beat or DONE)
    task automatic start0(input string tag);
        check_val({tag, "_rdy"}, int'(cr0), 1);
        cv0 = 1'b1;
        tick();
        cv0 = 1'b0;
        check_val({tag, "_busy"}, int'(cr0), 0);
        repeat (16) tick();
        check_val({tag, "_stats_info"}, int'(iv0), 0);
        check_val({tag, "_stats_done"}, int'(done0), 0);
        tick();
    endtask

    task automatic stats0(input string tag, input int tc, input int t1, input int tz);
        check_val({tag, "_info"}, int'(iv0), 1);
        check_val({tag, "_tc"}, int'(tc0), tc);
        check_val({tag, "_t1"}, int'(t10), t1);
        check_val({tag, "_tz"}, int'(tz0), tz);
    endtask

    task automatic beats0(input string tag, input int nb, input int stall_beat);
        for (int b = 0; b < nb; b++) begin
            if (b == stall_beat) begin
                lvl_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check_val($sformatf("%s_hold_vld%0d", tag, b), int'(lv0), 1);
                    check_val($sformatf("%s_hold_lvl%0d", tag, b), int'(ll0), exp_lvl[b]);
                    check_val($sformatf("%s_hold_run%0d", tag, b), int'(lr0), exp_run[b]);
                    check_val($sformatf("%s_hold_last%0d", tag, b), int'(last0), 0);
                end
                lvl_ready = 1'b1;
            end
            check_val($sformatf("%s_vld%0d", tag, b), int'(lv0), 1);
            check_val($sformatf("%s_lvl%0d", tag, b), int'(ll0), exp_lvl[b]);
            check_val($sformatf("%s_run%0d", tag, b), int'(lr0), exp_run[b]);
            check_val($sformatf("%s_last%0d", tag, b), int'(last0), (b == nb - 1) ? 1 : 0);
            tick();
        end
        check_val({tag, "_done"}, int'(done0), 1);
        check_val({tag, "_done_vld"}, int'(lv0), 0);
        check_val({tag, "_done_info"}, int'(iv0), 1);
        tick();
        check_val({tag, "_idle_rdy"}, int'(cr0), 1);
        check_val({tag, "_idle_done"}, int'(done0), 0);
    endtask

    initial begin
        rst = 1'b1;
        h264_reset = 1'b0;
        cv0 = 1'b0;
        cv1 = 1'b0;
        lvl_ready = 1'b1;
        clear_coef();
        repeat (2) tick();
        check_val("rst_rdy", int'(cr0), 1);
        check_val("rst_vld", int'(lv0), 0);
        check_val("rst_done", int'(done0), 0);
        check_val("rst_info", int'(iv0), 0);
        check_val("rst_rdy_ac", int'(cr1), 1);
        rst = 1'b0;
        tick();

        // All-zero block: DONE on cycle 18, no beats
        clear_coef();
        start0("zero");
        stats0("zero", 0, 0, 0);
        beats0("zero", 0, -1);

        set_mixed();
        start0("mixed");
        stats0("mixed", 5, 3, 4);
        beats0("mixed", 5, -1);

        set_mixed();
        start0("stall");
        stats0("stall", 5, 3, 4);
        beats0("stall", 5, 1);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                coef_i[r][c] = 15'sd2;
        for (int i = 0; i < 16; i++) begin
            exp_lvl[i] = 2;
            exp_run[i] = 0;
        end
        start0("full");
        stats0("full", 16, 0, 0);
        beats0("full", 16, -1);

        // AC-only instance: every milestone one cycle earlier
        clear_coef();
        coef_i[0][0] = 15'sd7;
        coef_i[3][3] = -15'sd1;
        check_val("ac_rdy", int'(cr1), 1);
        cv1 = 1'b1;
        tick();
        cv1 = 1'b0;
        repeat (15) tick();
        check_val("ac_stats_info", int'(iv1), 0);
        tick();
        check_val("ac_info", int'(iv1), 1);
        check_val("ac_tc", int'(tc1), 1);
        check_val("ac_t1", int'(t11), 1);
        check_val("ac_tz", int'(tz1), 14);
        check_val("ac_vld", int'(lv1), 1);
        check_val("ac_lvl", int'(ll1), -1);
        check_val("ac_run", int'(lr1), 14);
        check_val("ac_last", int'(last1), 1);
        tick();
        check_val("ac_done", int'(done1), 1);
        check_val("ac_done_vld", int'(lv1), 0);
        tick();
        check_val("ac_idle_rdy", int'(cr1), 1);

        // Synchronous clear while beat 3 is on the bus
        set_mixed();
        start0("hrst");
        stats0("hrst", 5, 3, 4);
        tick();
        tick();
        check_val("hrst_beat3_lvl", int'(ll0), -1);
        check_val("hrst_beat3_run", int'(lr0), 2);
        h264_reset = 1'b1;
        tick();
        h264_reset = 1'b0;
        check_val("hrst_vld", int'(lv0), 0);
        check_val("hrst_rdy", int'(cr0), 1);
        check_val("hrst_done", int'(done0), 0);
        check_val("hrst_info", int'(iv0), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("hrst_nodone%0d", i), int'(done0), 0);
        end

        // Asynchronous reset mid-SCAN takes effect between edges
        set_mixed();
        cv0 = 1'b1;
        tick();
        cv0 = 1'b0;
        repeat (4) tick();
        check_val("arst_scan_rdy", int'(cr0), 0);
        rst = 1'b1;
        #2;
        check_val("arst_rdy", int'(cr0), 1);
        check_val("arst_vld", int'(lv0), 0);
        check_val("arst_info", int'(iv0), 0);
        check_val("arst_done", int'(done0), 0);
        tick();
        rst = 1'b0;
        tick();

        set_mixed();
        start0("again");
        stats0("again", 5, 3, 4);
        beats0("again", 5, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
